// File: rtl/load_store_unit_if.sv
// Bus bundle between the CPU datapath, the load/store unit and the memory port.
// The master side is the CPU plus memory model; the slave side is the LSU.
interface load_store_unit_if;
  // Request channel from the control unit
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Completion channel back to the control unit
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // Word-aligned memory port
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word/half/byte little-endian access
// to a word-aligned memory, read-modify-write for sub-word stores.
// All outputs come from registers and are forced to zero while reset is high.
module load_store_unit #(
  parameter int MEM_LAT = 1
) (
  input logic             clock,
  input logic             reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [2:0] LAST_READ = 3'(MEM_LAT);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic        write_r;
  logic [31:0] wdata_r;
  logic        mem_en_r;
  logic        mem_wr_r;
  logic [31:0] mem_wdata_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;

  // Misaligned or illegal-size requests are rejected without touching memory
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      2'b00:   bad = (lane != 2'b00);
      2'b01:   bad = lane[0];
      2'b10:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the addressed lane and sign/zero extend it
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] res;
    logic [15:0] h;
    logic [7:0]  b;
    h = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    case (size)
      2'b01:   res = {{16{sgn & h[15]}}, h};
      2'b10:   res = {{24{sgn & b[7]}}, b};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the store data onto its lane of the word read from memory
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] res;
    res = word;
    case (size)
      2'b01: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      2'b10: begin
        case (lane)
          2'b00:   res[7:0]   = wdata[7:0];
          2'b01:   res[15:8]  = wdata[7:0];
          2'b10:   res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Transaction FSM; every output flop is updated on the state transition that needs it
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      addr_r       <= 32'h0;
      size_r       <= 2'b00;
      signed_r     <= 1'b0;
      write_r      <= 1'b0;
      wdata_r      <= 32'h0;
      mem_en_r     <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_wdata_r  <= 32'h0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'h0;
          resp_err_r   <= 1'b0;
          if (bus.req_valid) begin
            addr_r   <= bus.req_addr;
            size_r   <= bus.req_size;
            signed_r <= bus.req_signed;
            write_r  <= bus.req_write;
            wdata_r  <= bus.req_wdata;
            cnt      <= 3'd0;
            if (req_bad(bus.req_size, bus.req_addr[1:0])) begin
              state        <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else if (bus.req_write && bus.req_size == 2'b00) begin
              state       <= WRITE;
              mem_en_r    <= 1'b1;
              mem_wr_r    <= 1'b1;
              mem_wdata_r <= bus.req_wdata;
            end else begin
              state    <= READ;
              mem_en_r <= 1'b1;
            end
          end
        end
        READ: begin
          if (cnt == LAST_READ) begin
            if (write_r) begin
              state       <= WRITE;
              mem_wr_r    <= 1'b1;
              mem_wdata_r <= store_merge(bus.mem_rdata, wdata_r, addr_r[1:0], size_r);
            end else begin
              state        <= RESP;
              mem_en_r     <= 1'b0;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= load_extend(bus.mem_rdata, addr_r[1:0], size_r, signed_r);
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WRITE: begin
          state        <= RESP;
          mem_en_r     <= 1'b0;
          mem_wr_r     <= 1'b0;
          mem_wdata_r  <= 32'h0;
          resp_valid_r <= 1'b1;
        end
        RESP: begin
          state        <= IDLE;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'h0;
          resp_err_r   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Reset gates every output so a reset during WRITE never reaches memory
  assign bus.req_ready  = (state == IDLE) & ~reset;
  assign bus.mem_addr   = (mem_en_r & ~reset) ? {addr_r[31:2], 2'b00} : 32'h0;
  assign bus.mem_wr     = mem_wr_r & ~reset;
  assign bus.mem_wdata  = reset ? 32'h0 : mem_wdata_r;
  assign bus.resp_valid = resp_valid_r & ~reset;
  assign bus.resp_rdata = reset ? 32'h0 : resp_rdata_r;
  assign bus.resp_err   = resp_err_r & ~reset;

endmodule
